servo_array: RTL and testbench
==============================

SERVO_ARRAY -- requirements
Module: servo_array

Interface
REQ-001 Parameter N_CH, default 4, number of independent servo channels (1..16).
REQ-002 Parameter PERIOD, default 500000, frame length in clk ticks (20 ms at 25 MHz).
REQ-003 Parameter MIN_W, default 25000, minimum pulse width in ticks (0 deg).
REQ-004 Parameter MAX_W, default 50000, maximum pulse width in ticks (180 deg).
REQ-005 Parameter STEP, default 250, width change per motion update in ticks.
REQ-006 Parameter DIV, default 2, frames between motion updates (>=1).
REQ-007 Parameter W, default 20, width of counters and pulse values; $clog2(PERIOD) <= W.
REQ-008 clk  in  1  system clock, 25 MHz.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 cmd_valid  in  1  command present.
REQ-011 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-012 cmd_ch  in  $clog2(N_CH)  target channel.
REQ-013 cmd_mode  in  2  0=HOLD, 1=SWEEP, 2=TRACK, 3=reserved (treated as HOLD).
REQ-014 cmd_target  in  W  target width in ticks for TRACK.
REQ-015 servo_pin  out  N_CH  registered PWM outputs.
REQ-016 dir  out  N_CH  per-channel direction, 0=rising, 1=falling.
REQ-017 at_target  out  N_CH  channel width equals its clamped target.
REQ-018 frame_tick  out  1  one-cycle pulse when the frame counter is 0.

Function
REQ-019 Shared frame counter SHALL count 0..PERIOD-1 and wrap to 0, so the frame is exactly PERIOD ticks.
REQ-020 servo_pin[i] SHALL be registered as (frame counter < width[i]), one cycle latency.
REQ-021 Width[i] SHALL change only in the cycle where the frame counter is 0; no mid-pulse change.
REQ-022 A divider SHALL count frames 0..DIV-1; a motion update SHALL occur only at the frame boundary where it reaches DIV-1.
REQ-023 cmd_ready SHALL be 1 whenever out of reset; a command is accepted in any cycle.
REQ-024 An accepted command SHALL update mode[cmd_ch] and target[cmd_ch] immediately; target is clamped to [MIN_W, MAX_W] on capture.
REQ-025 A cmd_ch >= N_CH SHALL be accepted and ignored.
REQ-026 A command accepted in the same cycle as a motion update SHALL NOT affect that update; it takes effect at the next one.
REQ-027 HOLD: width unchanged.
REQ-028 SWEEP rising: width = min(width+STEP, MAX_W); when the result equals MAX_W, dir <= 1.
REQ-029 SWEEP falling: width = max(width-STEP, MIN_W); when the result equals MIN_W, dir <= 0.
REQ-030 TRACK: width moves toward target by min(STEP, |target-width|), with no overshoot; dir reflects the last move direction.
REQ-031 Width SHALL never leave [MIN_W, MAX_W]; the arithmetic uses W+1 bits to prevent wrap.
REQ-032 at_target[i] SHALL be combinational (width[i] == target[i]).
REQ-033 Entering SWEEP SHALL keep the current width and dir.

Reset
REQ-034 While rst_n=0: frame counter 0, divider 0, all widths MIN_W, targets MIN_W, modes HOLD, dir 0, servo_pin 0, frame_tick 0, cmd_ready 0.
REQ-035 Reset assertion mid-pulse SHALL drop servo_pin asynchronously; after release, the first frame starts at counter 0.

Structure
REQ-036 Mode enum and default timing constants SHALL live in package servo_pkg.
REQ-037 Per-channel width/dir/target logic SHALL be sub-module servo_chan, instantiated N_CH times with a shared frame counter and update strobe.

Verification
Test parameters: PERIOD=100, MIN_W=10, MAX_W=20, STEP=3, DIV=1.
REQ-038 Reset release, no commands -> all pins high 10 of every 100 cycles, frame_tick every 100 cycles.
REQ-039 SWEEP ch0 -> widths 13,16,19,20 (dir=1),17,14,11,10 (dir=0), one per frame.
REQ-040 TRACK ch1, target 15 -> widths 13,15 then hold; at_target=1. Target 99 -> clamped 20.
REQ-041 Command issued exactly at the update cycle -> old mode applied this frame, new mode at the next frame.
REQ-042 rst_n low at counter 5 with ch2 width 18 -> pin low immediately; after release, width 10 and mode HOLD.
REQ-043 cmd_ch=N_CH -> no channel state changes.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo array: channel modes, default timing
// constants and a helper that sizes the channel-select field.
package servo_pkg;

    // Per-channel motion mode; the reserved code behaves like HOLD.
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'd0,
        MODE_SWEEP = 2'd1,
        MODE_TRACK = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    // Defaults: 25 MHz clock, 20 ms frame, 1..2 ms pulse range.
    localparam int DEF_N_CH   = 4;
    localparam int DEF_PERIOD = 500000;
    localparam int DEF_MIN_W  = 25000;
    localparam int DEF_MAX_W  = 50000;
    localparam int DEF_STEP   = 250;
    localparam int DEF_DIV    = 2;
    localparam int DEF_W      = 20;

    // Width of the channel-select field; a single channel still gets one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servo_chan.sv
// One servo channel: holds mode/target, steps its pulse width on the shared
// update strobe and drives a registered PWM pin from the shared frame counter.
module servo_chan
    import servo_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int MIN_W = DEF_MIN_W,
    parameter int MAX_W = DEF_MAX_W,
    parameter int STEP  = DEF_STEP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         active,
    input  logic         upd,
    input  logic [W-1:0] frame_cnt,
    input  logic         cmd_we,
    input  logic [1:0]   cmd_mode,
    input  logic [W-1:0] cmd_target,
    output logic         pin,
    output logic         dir,
    output logic         at_target
);

    // Arithmetic is done one bit wider so width+STEP can never wrap.
    localparam logic [W:0] MIN_X  = (W+1)'(MIN_W);
    localparam logic [W:0] MAX_X  = (W+1)'(MAX_W);
    localparam logic [W:0] STEP_X = (W+1)'(STEP);

    mode_e        mode;
    logic [W-1:0] width;
    logic [W-1:0] target;
    logic [W-1:0] nxt_w;
    logic         nxt_dir;
    logic [W:0]   cap_x;
    logic [W-1:0] cap_clamped;

    logic [W:0] w_x;
    logic [W:0] t_x;
    logic [W:0] up_sum;
    logic [W:0] up_gap;
    logic [W:0] dn_gap;

    assign w_x    = {1'b0, width};
    assign t_x    = {1'b0, target};
    assign cap_x  = {1'b0, cmd_target};
    assign up_sum = w_x + STEP_X;
    assign up_gap = t_x - w_x;
    assign dn_gap = w_x - t_x;

    assign at_target = (width == target);

    // Clamp an incoming target into the legal pulse range.
    always_comb begin
        cap_clamped = cmd_target;
        if (cap_x < MIN_X)
            cap_clamped = MIN_W[W-1:0];
        else if (cap_x > MAX_X)
            cap_clamped = MAX_W[W-1:0];
    end

    // Next width/direction for a motion update in the current mode.
    always_comb begin
        nxt_w   = width;
        nxt_dir = dir;
        case (mode)
            MODE_SWEEP: begin
                if (!dir) begin
                    if (up_sum >= MAX_X) begin
                        nxt_w   = MAX_W[W-1:0];
                        nxt_dir = 1'b1;
                    end else begin
                        nxt_w = up_sum[W-1:0];
                    end
                end else begin
                    if (w_x <= MIN_X + STEP_X) begin
                        nxt_w   = MIN_W[W-1:0];
                        nxt_dir = 1'b0;
                    end else begin
                        nxt_w = width - STEP_X[W-1:0];
                    end
                end
            end
            MODE_TRACK: begin
                if (t_x > w_x) begin
                    nxt_w   = (up_gap > STEP_X) ? up_sum[W-1:0] : target;
                    nxt_dir = 1'b0;
                end else if (t_x < w_x) begin
                    nxt_w   = (dn_gap > STEP_X) ? (width - STEP_X[W-1:0]) : target;
                    nxt_dir = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Motion state changes only on the update strobe; commands land any cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width  <= MIN_W[W-1:0];
            dir    <= 1'b0;
            mode   <= MODE_HOLD;
            target <= MIN_W[W-1:0];
        end else begin
            if (upd) begin
                width <= nxt_w;
                dir   <= nxt_dir;
            end
            if (cmd_we) begin
                mode   <= mode_e'(cmd_mode);
                target <= cap_clamped;
            end
        end
    end

    // Registered PWM: high while the frame counter is below the width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pin <= 1'b0;
        else
            pin <= active && (frame_cnt < width);
    end

endmodule

// File: rtl/servo_array.sv
// Array of servo PWM channels sharing one frame counter and one motion
// divider. Commands are always accepted (cmd_valid && cmd_ready) outside reset.
module servo_array
    import servo_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int PERIOD = DEF_PERIOD,
    parameter int MIN_W  = DEF_MIN_W,
    parameter int MAX_W  = DEF_MAX_W,
    parameter int STEP   = DEF_STEP,
    parameter int DIV    = DEF_DIV,
    parameter int W      = DEF_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ch_w(N_CH)-1:0]   cmd_ch,
    input  logic [1:0]              cmd_mode,
    input  logic [W-1:0]            cmd_target,
    output logic [N_CH-1:0]         servo_pin,
    output logic [N_CH-1:0]         dir,
    output logic [N_CH-1:0]         at_target,
    output logic                    frame_tick
);

    localparam logic [W-1:0] LAST_CNT = W'(PERIOD - 1);
    localparam logic [W-1:0] LAST_DIV = W'(DIV - 1);

    logic         active;
    logic [W-1:0] frame_cnt;
    logic [W-1:0] div_cnt;
    logic         upd;
    logic         cmd_fire;

    // The counter holds at 0 for the first cycle out of reset so the first
    // frame after release starts cleanly at count 0.
    assign frame_tick = active && (frame_cnt == '0);
    assign cmd_ready  = active;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign upd        = frame_tick && (div_cnt == LAST_DIV);

    // Out-of-reset flag gating the counter, ready and pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            active <= 1'b0;
        else
            active <= 1'b1;
    end

    // Shared frame counter 0..PERIOD-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (active)
            frame_cnt <= (frame_cnt == LAST_CNT) ? '0 : frame_cnt + 1'b1;
    end

    // Frame divider; motion updates fire on the boundary where it reads DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (frame_tick)
            div_cnt <= (div_cnt == LAST_DIV) ? '0 : div_cnt + 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        logic we;
        assign we = cmd_fire && (32'(cmd_ch) == i);

        servo_chan #(
            .W     (W),
            .MIN_W (MIN_W),
            .MAX_W (MAX_W),
            .STEP  (STEP)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .active     (active),
            .upd        (upd),
            .frame_cnt  (frame_cnt),
            .cmd_we     (we),
            .cmd_mode   (cmd_mode),
            .cmd_target (cmd_target),
            .pin        (servo_pin[i]),
            .dir        (dir[i]),
            .at_target  (at_target[i])
        );
    end

endmodule

// File: tb/tb_servo_array.sv
// Directed bench for servo_array with a short frame (PERIOD=100, range 10..20,
// STEP=3, DIV=1). Pulse widths are measured from the pins over whole frames.
module tb_servo_array;

    localparam int N_CH   = 3;
    localparam int PERIOD = 100;
    localparam int MIN_W  = 10;
    localparam int MAX_W  = 20;
    localparam int STEP   = 3;
    localparam int DIV    = 1;
    localparam int W      = 20;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_ch;
    logic [1:0]      cmd_mode;
    logic [W-1:0]    cmd_target;
    logic [N_CH-1:0] servo_pin;
    logic [N_CH-1:0] dir;
    logic [N_CH-1:0] at_target;
    logic            frame_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_cnt[N_CH];

    servo_array #(
        .N_CH(N_CH), .PERIOD(PERIOD), .MIN_W(MIN_W), .MAX_W(MAX_W),
        .STEP(STEP), .DIV(DIV), .W(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_mode   (cmd_mode),
        .cmd_target (cmd_target),
        .servo_pin  (servo_pin),
        .dir        (dir),
        .at_target  (at_target),
        .frame_tick (frame_tick)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_cmd(input int ch, input logic [1:0] mode, input int tgt);
        cmd_valid  = 1'b1;
        cmd_ch     = 2'(ch);
        cmd_mode   = mode;
        cmd_target = W'(tgt);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Advance to the next negedge where frame_tick is high (bounded).
    task automatic wait_tick();
        bit found = 0;
        for (int k = 0; k < 2 * PERIOD && !found; k++) begin
            @(negedge clk);
            if (frame_tick) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_tick: no frame_tick within %0d cycles (got none, required one)", 2 * PERIOD);
        end
    endtask

    // From a frame_tick negedge, count pin-high cycles over one frame; ends
    // on the next frame_tick negedge. Any pending command is dropped after
    // the first cycle.
    task automatic measure();
        int ticks = 0;
        for (int c = 0; c < N_CH; c++) hi_cnt[c] = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            for (int c = 0; c < N_CH; c++)
                if (servo_pin[c]) hi_cnt[c]++;
            if (frame_tick) ticks++;
        end
        n_checks++;
        if (ticks != 1 || frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_period: ticks in frame=%0d last_tick=%b, required 1 and 1", ticks, frame_tick);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_mode  = '0;
        cmd_target = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (servo_pin !== 3'b000 || frame_tick !== 1'b0 || cmd_ready !== 1'b0 || dir !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: pin=%b tick=%b ready=%b dir=%b, required 000 0 0 000",
                     servo_pin, frame_tick, cmd_ready, dir);
        end
        n_checks++;
        if (at_target !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_at_target: got %b required 111", at_target);
        end
        rst_n = 1'b1;
        wait_tick();
        for (int f = 0; f < 3; f++) begin
            measure();
            for (int c = 0; c < N_CH; c++) begin
                n_checks++;
                if (hi_cnt[c] != MIN_W) begin
                    n_fail++;
                    $display("FAIL idle_width ch%0d frame%0d: got %0d required %0d", c, f, hi_cnt[c], MIN_W);
                end
            end
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_sweep();
        int   exp_w[8] = '{13, 16, 19, 20, 17, 14, 11, 10};
        logic exp_d[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
        do_reset();
        wait_tick();
        repeat (5) @(negedge clk);
        send_cmd(0, 2'd1, 0);
        wait_tick();
        for (int f = 0; f < 8; f++) begin
            measure();
            n_checks++;
            if (hi_cnt[0] != exp_w[f] || dir[0] !== exp_d[f]) begin
                n_fail++;
                $display("FAIL sweep step%0d: width=%0d dir=%b required %0d %b",
                         f, hi_cnt[0], dir[0], exp_w[f], exp_d[f]);
            end
            n_checks++;
            if (hi_cnt[1] != MIN_W) begin
                n_fail++;
                $display("FAIL sweep_isolation step%0d: ch1 width=%0d required %0d", f, hi_cnt[1], MIN_W);
            end
        end
    endtask

    task automatic test_track();
        int exp_a[3] = '{13, 15, 15};
        int exp_b[3] = '{18, 20, 20};
        do_reset();
        wait_tick();
        repeat (5) @(negedge clk);
        send_cmd(1, 2'd2, 15);
        wait_tick();
        for (int f = 0; f < 3; f++) begin
            measure();
            n_checks++;
            if (hi_cnt[1] != exp_a[f] || at_target[1] !== (f > 0) || dir[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL track15 step%0d: width=%0d at=%b dir=%b required %0d %b 0",
                         f, hi_cnt[1], at_target[1], dir[1], exp_a[f], (f > 0));
            end
        end
        repeat (5) @(negedge clk);
        send_cmd(1, 2'd2, 99);
        n_checks++;
        if (at_target[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL track99_capture: at_target=%b required 0", at_target[1]);
        end
        wait_tick();
        for (int f = 0; f < 3; f++) begin
            measure();
            n_checks++;
            if (hi_cnt[1] != exp_b[f] || at_target[1] !== (f > 0)) begin
                n_fail++;
                $display("FAIL track99 step%0d: width=%0d at=%b required %0d %b",
                         f, hi_cnt[1], at_target[1], exp_b[f], (f > 0));
            end
        end
        repeat (5) @(negedge clk);
        send_cmd(1, 2'd2, 0);
        wait_tick();
        measure();
        n_checks++;
        if (hi_cnt[1] != 17 || dir[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL track_down: width=%0d dir=%b required 17 1", hi_cnt[1], dir[1]);
        end
    endtask

    task automatic test_update_boundary();
        int exp_w[4] = '{10, 13, 16, 16};
        do_reset();
        wait_tick();
        // SWEEP presented in the update cycle itself
        cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_mode = 2'd1; cmd_target = '0;
        measure();
        n_checks++;
        if (hi_cnt[0] != exp_w[0]) begin
            n_fail++;
            $display("FAIL boundary_old_mode: width=%0d required %0d", hi_cnt[0], exp_w[0]);
        end
        measure();
        n_checks++;
        if (hi_cnt[0] != exp_w[1]) begin
            n_fail++;
            $display("FAIL boundary_new_mode: width=%0d required %0d", hi_cnt[0], exp_w[1]);
        end
        // HOLD presented in the update cycle: sweep still applies once
        cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_mode = 2'd0; cmd_target = '0;
        measure();
        n_checks++;
        if (hi_cnt[0] != exp_w[2]) begin
            n_fail++;
            $display("FAIL boundary_hold_late: width=%0d required %0d", hi_cnt[0], exp_w[2]);
        end
        measure();
        n_checks++;
        if (hi_cnt[0] != exp_w[3]) begin
            n_fail++;
            $display("FAIL boundary_hold: width=%0d required %0d", hi_cnt[0], exp_w[3]);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int exp_w[3] = '{13, 16, 18};
        do_reset();
        wait_tick();
        repeat (5) @(negedge clk);
        send_cmd(2, 2'd2, 18);
        wait_tick();
        for (int f = 0; f < 3; f++) begin
            measure();
            n_checks++;
            if (hi_cnt[2] != exp_w[f]) begin
                n_fail++;
                $display("FAIL pre_reset_track step%0d: width=%0d required %0d", f, hi_cnt[2], exp_w[f]);
            end
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (servo_pin[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pulse_high: pin=%b required 1", servo_pin[2]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (servo_pin !== 3'b000 || cmd_ready !== 1'b0 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_drop: pin=%b ready=%b tick=%b required 000 0 0",
                     servo_pin, cmd_ready, frame_tick);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_tick();
        for (int f = 0; f < 2; f++) begin
            measure();
            n_checks++;
            if (hi_cnt[2] != MIN_W || at_target !== 3'b111) begin
                n_fail++;
                $display("FAIL post_reset step%0d: width=%0d at=%b required %0d 111",
                         f, hi_cnt[2], at_target, MIN_W);
            end
        end
    endtask

    task automatic test_bad_channel();
        do_reset();
        wait_tick();
        repeat (5) @(negedge clk);
        cmd_valid = 1'b1; cmd_ch = 2'd3; cmd_mode = 2'd2; cmd_target = W'(20);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_ch_ready: got %b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (at_target !== 3'b111) begin
            n_fail++;
            $display("FAIL bad_ch_target: at_target=%b required 111", at_target);
        end
        send_cmd(3, 2'd1, 0);
        // reserved mode on ch1: target captured, width held
        send_cmd(1, 2'd3, 20);
        n_checks++;
        if (at_target !== 3'b101) begin
            n_fail++;
            $display("FAIL rsvd_capture: at_target=%b required 101", at_target);
        end
        wait_tick();
        for (int f = 0; f < 2; f++) begin
            measure();
            for (int c = 0; c < N_CH; c++) begin
                n_checks++;
                if (hi_cnt[c] != MIN_W) begin
                    n_fail++;
                    $display("FAIL bad_ch_hold ch%0d frame%0d: width=%0d required %0d", c, f, hi_cnt[c], MIN_W);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sweep();
        test_track();
        test_update_boundary();
        test_reset_mid_pulse();
        test_bad_channel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
